// File: rtl/sort_pkg.sv
// Shared types and helpers for the block sorter family.
package sort_pkg;

  typedef enum logic [2:0] {
    LOAD,
    INIT,
    POP,
    PART,
    PUSH,
    DRAIN
  } state_e;

  localparam int KEY_UNSIGNED = 0;
  localparam int KEY_SIGNED   = 1;
  localparam int KEY_FLOAT    = 2;

  // Index width: one extra bit so M itself and lo+1/pi+1 are representable.
  function automatic int idx_w(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sort_key_cmp.sv
// Combinational key comparator: maps words to unsigned-orderable keys and
// reports whether a sorts strictly before b in the requested direction.
module sort_key_cmp
  import sort_pkg::*;
#(
  parameter int N        = 32,
  parameter int KEY_MODE = KEY_FLOAT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         descend,
  output logic         a_before_b
);

  // Negative floats reverse magnitude order, so they are fully inverted;
  // everything else only needs the sign bit flipped.
  function automatic logic [N-1:0] key_of(input logic [N-1:0] x);
    logic [N-1:0] msb_flip;
    msb_flip = x ^ {1'b1, {(N-1){1'b0}}};
    if (KEY_MODE == KEY_UNSIGNED) return x;
    else if (KEY_MODE == KEY_SIGNED) return msb_flip;
    else return x[N-1] ? ~x : msb_flip;
  endfunction

  logic [N-1:0] key_a, key_b;

  // Strict comparison so equal keys are never treated as "before".
  always_comb begin
    key_a      = key_of(a);
    key_b      = key_of(b);
    a_before_b = descend ? (key_b < key_a) : (key_a < key_b);
  end

endmodule

// File: rtl/sort_stream.sv
// Block sorter: loads M words, sorts them in place with an iterative Lomuto
// quicksort over an explicit (lo, hi) stack, then streams them out.
module sort_stream
  import sort_pkg::*;
#(
  parameter int N        = 32,
  parameter int M        = 8,
  parameter int KEY_MODE = KEY_FLOAT
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         descend,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int IW = idx_w(M);
  localparam int AW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] LAST = IW'(M - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  state_e        state_q, state_d;
  logic [N-1:0]  arr_q [M];
  logic [N-1:0]  arr_d [M];
  logic [IW-1:0] stk_lo_q [M];
  logic [IW-1:0] stk_lo_d [M];
  logic [IW-1:0] stk_hi_q [M];
  logic [IW-1:0] stk_hi_d [M];
  logic [IW-1:0] sp_q, sp_d, k_q, k_d;
  logic [IW-1:0] lo_q, lo_d, hi_q, hi_d, i_q, i_d, j_q, j_d;
  logic          desc_q, desc_d;
  logic [IW-1:0] sp_t, top_t;
  logic [N-1:0]  cur, pivot;
  logic          cur_before;

  assign cur   = arr_q[j_q[AW-1:0]];
  assign pivot = arr_q[hi_q[AW-1:0]];

  sort_key_cmp #(
    .N        (N),
    .KEY_MODE (KEY_MODE)
  ) u_cmp (
    .a          (cur),
    .b          (pivot),
    .descend    (desc_q),
    .a_before_b (cur_before)
  );

  // Outputs plus next-state for the control FSM, the array and the range stack.
  always_comb begin
    in_ready  = (state_q == LOAD) && !rst;
    out_valid = (state_q == DRAIN) && !rst;
    out_data  = out_valid ? arr_q[k_q[AW-1:0]] : '0;
    out_last  = out_valid && (k_q == LAST);
    busy      = !rst && ((state_q == INIT) || (state_q == POP) ||
                         (state_q == PART) || (state_q == PUSH));

    state_d  = state_q;
    arr_d    = arr_q;
    stk_lo_d = stk_lo_q;
    stk_hi_d = stk_hi_q;
    sp_d     = sp_q;
    k_d      = k_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    i_d      = i_q;
    j_d      = j_q;
    desc_d   = desc_q;
    sp_t     = sp_q;
    top_t    = sp_q - ONE;

    case (state_q)
      LOAD: begin
        if (in_valid && in_ready) begin
          arr_d[k_q[AW-1:0]] = in_data;
          if (k_q == LAST) begin
            k_d     = '0;
            desc_d  = descend;
            state_d = INIT;
          end else begin
            k_d = k_q + ONE;
          end
        end
      end
      INIT: begin
        stk_lo_d[sp_q[AW-1:0]] = '0;
        stk_hi_d[sp_q[AW-1:0]] = LAST;
        sp_d    = sp_q + ONE;
        state_d = POP;
      end
      POP: begin
        if (sp_q == '0) begin
          state_d = DRAIN;
        end else begin
          lo_d    = stk_lo_q[top_t[AW-1:0]];
          hi_d    = stk_hi_q[top_t[AW-1:0]];
          i_d     = stk_lo_q[top_t[AW-1:0]];
          j_d     = stk_lo_q[top_t[AW-1:0]];
          sp_d    = top_t;
          state_d = PART;
        end
      end
      PART: begin
        // arr[hi] is untouched until the final swap, so it serves as the pivot.
        if (j_q < hi_q) begin
          if (cur_before) begin
            arr_d[i_q[AW-1:0]] = arr_q[j_q[AW-1:0]];
            arr_d[j_q[AW-1:0]] = arr_q[i_q[AW-1:0]];
            i_d = i_q + ONE;
          end
          j_d = j_q + ONE;
        end else begin
          arr_d[i_q[AW-1:0]]  = arr_q[hi_q[AW-1:0]];
          arr_d[hi_q[AW-1:0]] = arr_q[i_q[AW-1:0]];
          state_d = PUSH;
        end
      end
      PUSH: begin
        // i_q now holds the pivot's final position; only ranges of 2+ are kept.
        if ((i_q + ONE) < hi_q) begin
          stk_lo_d[sp_t[AW-1:0]] = i_q + ONE;
          stk_hi_d[sp_t[AW-1:0]] = hi_q;
          sp_t = sp_t + ONE;
        end
        if (i_q > (lo_q + ONE)) begin
          stk_lo_d[sp_t[AW-1:0]] = lo_q;
          stk_hi_d[sp_t[AW-1:0]] = i_q - ONE;
          sp_t = sp_t + ONE;
        end
        sp_d    = sp_t;
        state_d = POP;
      end
      DRAIN: begin
        if (out_ready) begin
          if (k_q == LAST) begin
            k_d     = '0;
            state_d = LOAD;
          end else begin
            k_d = k_q + ONE;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control state: FSM, stack pointer, word counter and latched direction.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= LOAD;
      sp_q    <= '0;
      k_q     <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      k_q     <= k_d;
      desc_q  <= desc_d;
    end
  end

  // Datapath storage: word array, stack entries and partition indices.
  always_ff @(posedge clock) begin
    arr_q    <= arr_d;
    stk_lo_q <= stk_lo_d;
    stk_hi_q <= stk_hi_d;
    lo_q     <= lo_d;
    hi_q     <= hi_d;
    i_q      <= i_d;
    j_q      <= j_d;
  end

endmodule

// File: doc/sort_stream.md
# sort_stream

Parametrised block sorter with valid/ready streaming. It accepts a block of M words of width N, sorts them in place with an iterative Lomuto quicksort driven by an explicit index stack, and streams the sorted block out. Key interpretation is selected at elaboration time: unsigned, signed two's complement, or IEEE-754 total order. Sort direction is selected per block at run time. It replaces the fixed-size, fixed-format sorter in the datapath and adds flow control on both sides.

## Interface
- N, 32: data/key width, ≥2
- M, 8: block depth, 2..64
- KEY_MODE, 2: 0 = unsigned, 1 = signed two's complement, 2 = IEEE-754 sign-magnitude total order
- clock  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input (LOAD state only)
- in_data  in  N  input word
- descend  in  1  1 = descending order; sampled on the beat that accepts the M-th word
- out_valid  out  1  sorted word present
- out_ready  in  1  downstream accepts
- out_data  out  N  sorted word
- out_last  out  1  marks the M-th output word
- busy  out  1  high from the cycle after the last load beat until the first out_valid

## Operation
- States:
  - LOAD: accept words; arr[k] ← in_data on in_valid&&in_ready, k increments; the M-th beat moves to INIT.
  - INIT: push range (0, M-1).
  - POP: if the stack is empty, go to DRAIN; otherwise pop (lo, hi) and go to PART.
  - PART:
    - Pivot = arr[hi]; i = j = lo.
    - Each cycle with j < hi: if before(arr[j], pivot), swap arr[i]/arr[j] and increment i; then increment j.
    - At j == hi: swap arr[i]/arr[hi], set pi = i, go to PUSH.
  - PUSH: in one cycle, push (pi+1, hi) if pi+1 < hi, then push (lo, pi-1) if pi > lo+1. Go to POP.
  - DRAIN: out_data = arr[k] with k starting at 0; k increments on out_valid&&out_ready. The handshake at k == M-1 returns to LOAD.
- Ranges with fewer than 2 elements are never pushed, so no negative or wrapped indices occur. Stack depth is M entries and cannot overflow.
- before(a, b): compare key(a) < key(b) unsigned. When descend is latched high, compare key(b) < key(a). Equal keys never swap with the pivot path; the sort is not required to be stable.
- key(x) by mode:
  - Mode 0: x.
  - Mode 1: x with its MSB inverted.
  - Mode 2: ~x if x[N-1] is set, else x with its MSB inverted. Result: -0 < +0, and NaNs are ordered by bit pattern.
- Index arithmetic uses clog2(M)+1 bits, unsigned, with no wrap.

## Timing
- Values while rst is high: in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0. Stack, k, and the latched descend are cleared.
- First cycle after rst deasserts: LOAD, in_ready=1.
- Reset mid-sort or mid-drain: the current block is discarded with no partial output. Beats presented while rst is high are not accepted.
- Load takes M accepted beats. Stalls (in_valid low) are allowed anywhere.
- Sort latency:
  - INIT: 1 cycle.
  - Each range: 1 cycle POP + (hi-lo+1) cycles PART + 1 cycle PUSH.
  - Final POP on the empty stack: 1 cycle.
  - Worst case (presorted input): about M²/2 + 3M cycles.
- out_valid asserts in the cycle after the final POP. out_data and out_last stay stable while out_valid && !out_ready.
- in_ready is 0 from INIT through the end of DRAIN. The first in_ready of the next block is in the cycle after the last output handshake.

## Structure
- Package sort_pkg:
  - State enum: LOAD, INIT, POP, PART, PUSH, DRAIN.
  - KEY_UNSIGNED=0, KEY_SIGNED=1, KEY_FLOAT=2.
  - Index-width function clog2(M)+1.
- Sub-module sort_key_cmp: combinational, parameters N and KEY_MODE, inputs a, b, descend, output a_before_b. It is reused by later merge blocks.
- arr and the stack are register arrays in the top module; PART needs two read ports and two write ports.

## Test plan
All scenarios use N=32, M=8.
- Mode 0, descend=0: load 5,3,8,1,9,2,7,4 → out 1,2,3,4,5,7,8,9; out_last only on 9.
- Mode 1: load FFFFFFFF,2,FFFFFFFB,0,7FFFFFFF,80000000,1,FFFFFFFE → 80000000,FFFFFFFB,FFFFFFFE,FFFFFFFF,0,1,2,7FFFFFFF.
- Mode 2: load BF800000,3F800000,80000000,00000000,40000000,C0000000,3F000000,7F800000 → C0000000,BF800000,80000000,00000000,3F000000,3F800000,40000000,7F800000.
- Presorted input 0..7:
  - With descend=1: output 7..0.
  - With descend=0: output 0..7.
  - In both cases, check sort cycle count against the worst-case formula and check there is no stack overflow.
- Backpressure:
  - out_ready pattern 1,0,1,0 and then low for 5 cycles: no lost or duplicated words, out_data stable while stalled, in_ready=0 throughout DRAIN.
  - in_valid gaps during load: result unchanged.
- Reset during PART of block A, then load block B of all-equal words 0x55: out_valid stays 0 until B has sorted, then B is output as eight 0x55 words with nothing from A.
